// File: rtl/bus_apb_bridge_if.sv
// Signal bundle between the request/ready bus master, the bridge and the APB completer.
// The bridge takes the slave modport; the environment (bus master plus completer) takes master.
interface bus_apb_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    bus_ena;
    logic [DATA_WIDTH/8-1:0] bus_wstb;
    logic [ADDR_WIDTH-1:0]   bus_addr;
    logic [DATA_WIDTH-1:0]   bus_wdata;
    logic                    bus_ready;
    logic [DATA_WIDTH-1:0]   bus_rdata;
    logic                    bus_slverr;

    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport slave (
        input  bus_ena, bus_wstb, bus_addr, bus_wdata, pready, prdata, pslverr,
        output bus_ready, bus_rdata, bus_slverr,
               psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );

    modport master (
        output bus_ena, bus_wstb, bus_addr, bus_wdata, pready, prdata, pslverr,
        input  bus_ready, bus_rdata, bus_slverr,
               psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );
endinterface

// File: rtl/bus_apb_bridge.sv
// Request/ready bus slave to APB4 requester bridge with optional PREADY timeout.
// Every output is a flop; one transfer in flight, minimum four-cycle issue interval.
module bus_apb_bridge #(
    parameter int         ADDR_WIDTH     = 32,
    parameter int         DATA_WIDTH     = 32,
    parameter int         TIMEOUT_CYCLES = 256,
    parameter logic [2:0] PPROT_VALUE    = 3'b000
) (
    input logic             clk,
    input logic             rst,
    bus_apb_bridge_if.slave bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  slverr_q, slverr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_wr;

    assign req_wr = |bus.bus_wstb;

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        ready_d   = ready_q;
        rdata_d   = rdata_q;
        slverr_d  = slverr_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.bus_ena) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = req_wr;
                    paddr_d  = bus.bus_addr;
                    pwdata_d = req_wr ? bus.bus_wdata : '0;
                    pstrb_d  = req_wr ? bus.bus_wstb : '0;
                    cnt_d    = '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // pready wins over the timeout when both land on the same cycle
                if (bus.pready) begin
                    state_d   = RESP;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    rdata_d   = pwrite_q ? '0 : bus.prdata;
                    slverr_d  = bus.pslverr;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    rdata_d   = '0;
                    slverr_d  = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d  = IDLE;
                ready_d  = 1'b0;
                rdata_d  = '0;
                slverr_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            slverr_q  <= slverr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.paddr      = paddr_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.pstrb      = pstrb_q;
    assign bus.pprot      = PPROT_VALUE;
    assign bus.bus_ready  = ready_q;
    assign bus.bus_rdata  = rdata_q;
    assign bus.bus_slverr = slverr_q;
endmodule

// File: doc/bus_apb_bridge.md
Name: bus_apb_bridge

Overview:
- Bridges the team's simple request/ready bus to an APB4 completer port.
- Sits directly downstream of the bus master: responds as the bus slave, issues APB SETUP/ACCESS transfers, and returns read data and error status.
- Adds an optional PREADY timeout so a hung peripheral cannot stall the bus master indefinitely.

Parameters:
- ADDR_WIDTH, 32, bus and APB address width.
- DATA_WIDTH, 32, bus and APB data width (multiple of 8).
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before abort; 0 disables the timeout.
- PPROT_VALUE, 3'b000, constant driven on pprot.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- bus_ena  input  1  request valid; held with stable request fields until bus_ready is seen.
- bus_wstb  input  DATA_WIDTH/8  byte write strobes; all-zero means read.
- bus_addr  input  ADDR_WIDTH  request address.
- bus_wdata  input  DATA_WIDTH  write data.
- bus_ready  output  1  one-cycle completion pulse.
- bus_rdata  output  DATA_WIDTH  read data, valid while bus_ready=1.
- bus_slverr  output  1  error flag, valid while bus_ready=1.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  ADDR_WIDTH  APB address.
- pwdata  output  DATA_WIDTH  APB write data.
- pstrb  output  DATA_WIDTH/8  APB write strobes.
- pprot  output  3  APB protection, equal to PPROT_VALUE.
- pready  input  1  completer ready.
- prdata  input  DATA_WIDTH  completer read data.
- pslverr  input  1  completer error.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high (rst). All flops are clocked on posedge clk.
- Reset values: state IDLE, all outputs 0, timeout counter 0. pprot is the constant PPROT_VALUE.
- All outputs are registered.
- State machine: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On bus_ena=1, capture addr, wdata and wstb into registers, then go to SETUP.
  - Captured values: pwrite=|bus_wstb; pstrb=bus_wstb if write, else 0; paddr=bus_addr; pwdata=bus_wdata on write, else 0.
- SETUP (one cycle): psel=1, penable=0. Next state is ACCESS unconditionally.
- ACCESS:
  - psel=1, penable=1; paddr, pwrite, pwdata and pstrb are held stable.
  - The counter increments each ACCESS cycle.
  - If pready=1: register bus_rdata = pwrite ? 0 : prdata, and bus_slverr = pslverr. Go to RESP.
  - Else if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1: abort with bus_rdata=0, bus_slverr=1, then go to RESP.
- APB de-assertion: on leaving ACCESS, psel=0 and penable=0 in the same edge; no back-to-back APB transfer without a bus handshake.
- RESP (one cycle):
  - bus_ready=1; bus_rdata and bus_slverr are valid.
  - Next state IDLE. bus_ready, bus_rdata and bus_slverr return to 0 in IDLE.
- Latency: request sampled at edge N gives psel at N+1, penable at N+2, bus_ready at N+3 (zero-wait completer).
- Back-to-back: minimum 4-cycle issue interval. IDLE re-samples bus_ena one cycle after the bus_ready cycle, so a master holding bus_ena through bus_ready starts a new transfer with the new fields.
- Request changes: bus_ena deasserting or request fields changing after capture are ignored until RESP.
- Reset mid-transfer: outputs drop to 0 immediately (asynchronously). The transfer is dropped with no bus_ready.
- pready/pslverr are ignored outside ACCESS. pslverr with pready=0 is ignored.
- Counter: width clog2(TIMEOUT_CYCLES+1), minimum 1. Cleared on entering SETUP. Never wraps, because the abort fires first.
- Data ordering: bus_rdata is captured from prdata in the same cycle pready=1 is sampled.

Test Plan:
- Reset/idle: rst pulse, bus_ena=0 for 10 cycles -> psel, penable and bus_ready stay 0; pprot=0.
- Zero-wait write: wstb=4'hF, addr=0x100, wdata=0xDEADBEEF, pready=1 -> psel at N+1, penable at N+2, pwrite=1, pstrb=F, bus_ready at N+3, slverr=0.
- Wait-state read: wstb=0, addr=0x204, pready low 3 ACCESS cycles then high with prdata=0x12345678 -> pstrb=0, bus_rdata=0x12345678 on the single bus_ready cycle (N+6).
- Error and partial strobe: wstb=4'b0011, pslverr=1 with pready=1 -> pstrb=3, bus_slverr=1, bus_rdata=0.
- Timeout: TIMEOUT_CYCLES=4, pready held 0 -> exactly 4 ACCESS cycles, then bus_ready=1, bus_slverr=1, bus_rdata=0, psel=0. A later request completes normally.
- Back-to-back and reset mid-transfer:
  - bus_ena held high across two requests -> second psel 4 cycles after the first; no duplicate transfer.
  - rst asserted during ACCESS -> psel and penable low immediately, no bus_ready; the next request works.
